// File: rtl/osc_seq_clkgen_if.sv
// osc_seq_clkgen_if: bundles the sequencer control, divider programming and
// strobe outputs of osc_seq_clkgen.
//   master : drives req_on, req_off, div_wr, div_ch, div_val; observes outputs
//   slave  : the osc_seq_clkgen side (drives osc_pu, osc_en, ready, clk_en, busy)
interface osc_seq_clkgen_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              req_on;
    logic              req_off;
    logic              osc_pu;
    logic              osc_en;
    logic              ready;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [DIV_W-1:0]  div_val;
    logic [NUM_CH-1:0] clk_en;
    logic              busy;

    modport master (
        output req_on, req_off, div_wr, div_ch, div_val,
        input  osc_pu, osc_en, ready, clk_en, busy
    );

    modport slave (
        input  req_on, req_off, div_wr, div_ch, div_val,
        output osc_pu, osc_en, ready, clk_en, busy
    );
endinterface

// File: rtl/osc_seq_clkgen.sv
// osc_seq_clkgen: HF oscillator power-up/enable sequencer with NUM_CH
// runtime-programmable clock-enable strobe generators.
//   clk : free-running system clock
//   rst : asynchronous reset, active-high
//   bus : osc_seq_clkgen_if.slave
//         req_on/req_off         single-cycle sequencer requests
//         osc_pu/osc_en          oscillator pins
//         ready/busy             sequencer status
//         div_wr/div_ch/div_val  per-channel divide programming (period = div_val+1)
//         clk_en                 per-channel one-cycle enable strobes
// Optional macro OSC_SEQ_AUTO_ON_EN: start the power-up sequence on the first
// edge after reset release without needing req_on.
module osc_seq_clkgen #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned PU_CYCLES = 4800,
    parameter int unsigned EN_CYCLES = 16,
    parameter int unsigned DIV_RST   = 0
) (
    input logic             clk,
    input logic             rst,
    osc_seq_clkgen_if.slave bus
);
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SEQ_MAX = (PU_CYCLES > EN_CYCLES) ? PU_CYCLES : EN_CYCLES;
    localparam int unsigned SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam logic [SEQ_W-1:0] PU_LAST  = SEQ_W'(PU_CYCLES - 1);
    localparam logic [SEQ_W-1:0] EN_LAST  = SEQ_W'(EN_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

    typedef enum logic [2:0] {StOff, StPwrup, StSettle, StRun, StShutdn} state_e;

    state_e            state_q;
    logic [SEQ_W-1:0]  seq_cnt_q;
    logic              osc_pu_q;
    logic              osc_en_q;
    logic              ready_q;
    logic              busy_q;
    logic [NUM_CH-1:0] clk_en_q;
    logic [DIV_W-1:0]  shadow_q   [NUM_CH];
    logic [DIV_W-1:0]  shadow_nxt [NUM_CH];
    logic [DIV_W-1:0]  div_q      [NUM_CH];
    logic [DIV_W-1:0]  cnt_q      [NUM_CH];
    logic              start;
    logic              run_stay;
    logic              run_enter;

`ifdef OSC_SEQ_AUTO_ON_EN
    // One-shot flag: acts as a req_on on the first edge after reset release.
    logic auto_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) auto_q <= 1'b1;
        else     auto_q <= 1'b0;
    end
    assign start = bus.req_on | auto_q;
`else
    assign start = bus.req_on;
`endif

    // Shadow values after this cycle's write; out-of-range div_ch matches nothing.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            shadow_nxt[i] = shadow_q[i];
            if (bus.div_wr && (bus.div_ch == CH_W'(i))) shadow_nxt[i] = bus.div_val;
        end
    end

    assign run_stay  = (state_q == StRun) && !bus.req_off;
    assign run_enter = (state_q == StSettle) && !bus.req_off && (seq_cnt_q == EN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StOff;
            seq_cnt_q <= '0;
            osc_pu_q  <= 1'b0;
            osc_en_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            clk_en_q  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= DIV_INIT;
                div_q[i]    <= DIV_INIT;
                cnt_q[i]    <= '0;
            end
        end else begin
            unique case (state_q)
                StOff: begin
                    if (start && !bus.req_off) begin
                        state_q   <= StPwrup;
                        osc_pu_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        seq_cnt_q <= '0;
                    end
                end
                StPwrup: begin
                    if (bus.req_off) begin
                        // Abort before the enable pin was ever raised.
                        state_q   <= StOff;
                        osc_pu_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        seq_cnt_q <= '0;
                    end else if (seq_cnt_q == PU_LAST) begin
                        state_q   <= StSettle;
                        osc_en_q  <= 1'b1;
                        seq_cnt_q <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (bus.req_off) begin
                        state_q   <= StShutdn;
                        osc_en_q  <= 1'b0;
                        seq_cnt_q <= '0;
                    end else if (seq_cnt_q == EN_LAST) begin
                        state_q   <= StRun;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b0;
                        seq_cnt_q <= '0;
                    end else begin
                        seq_cnt_q <= seq_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (bus.req_off) begin
                        state_q  <= StShutdn;
                        osc_en_q <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                StShutdn: begin
                    // osc_pu stays high for exactly this one cycle.
                    state_q  <= StOff;
                    osc_pu_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q   <= StOff;
                    seq_cnt_q <= '0;
                    osc_pu_q  <= 1'b0;
                    osc_en_q  <= 1'b0;
                    ready_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase

            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= shadow_nxt[i];
                if (run_stay) begin
                    // New divide takes effect only at a period boundary.
                    if (cnt_q[i] == div_q[i]) begin
                        cnt_q[i]    <= '0;
                        div_q[i]    <= shadow_nxt[i];
                        clk_en_q[i] <= 1'b1;
                    end else begin
                        cnt_q[i]    <= cnt_q[i] + DIV_W'(1);
                        clk_en_q[i] <= 1'b0;
                    end
                end else begin
                    // Counters parked at 0 so all channels strobe together on RUN entry.
                    cnt_q[i]    <= '0;
                    div_q[i]    <= shadow_nxt[i];
                    clk_en_q[i] <= run_enter;
                end
            end
        end
    end

    assign bus.osc_pu = osc_pu_q;
    assign bus.osc_en = osc_en_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.clk_en = clk_en_q;
endmodule

// File: tb/tb_osc_seq_clkgen.sv
// Directed bench for osc_seq_clkgen with a small expected-value scoreboard.
module tb_osc_seq_clkgen;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned PU     = 20;
    localparam int unsigned EN     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    string      tag_q[$];
    logic [6:0] exp_q[$];
    logic [6:0] obs;

    osc_seq_clkgen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    osc_seq_clkgen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .PU_CYCLES(PU),
        .EN_CYCLES(EN),
        .DIV_RST  (0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // {osc_pu, osc_en, ready, busy, clk_en[2:0]}
    assign obs = {bus.osc_pu, bus.osc_en, bus.ready, bus.busy, bus.clk_en};

    function automatic logic [6:0] v(input logic pu, input logic en, input logic rdy,
                                     input logic bsy, input logic [2:0] ce);
        return {pu, en, rdy, bsy, ce};
    endfunction

    task automatic push(input string tag, input logic [6:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic compare_head();
        string      tag;
        logic [6:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: observed %b, nothing expected", obs);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %b required %b", tag, obs, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic [6:0] e);
        push(tag, e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic check_now(input string tag, input logic [6:0] e);
        push(tag, e);
        compare_head();
    endtask

    initial begin
        logic ch1;
        logic ch2;
        bus.req_on  = 1'b0;
        bus.req_off = 1'b0;
        bus.div_wr  = 1'b0;
        bus.div_ch  = '0;
        bus.div_val = '0;

        #1 rst = 1'b1;
        #1 check_now("reset_state", 7'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef OSC_SEQ_AUTO_ON_EN
        step("auto_on", v(1, 0, 0, 1, 3'b000));
        bus.req_off = 1'b1;
        step("auto_abort", 7'b0);
        bus.req_off = 1'b0;
`else
        step("no_auto_on", 7'b0);
`endif
        step("idle", 7'b0);

        // Program dividers while OFF: ch0=0, ch1=3, ch2=2, plus an out-of-range write.
        bus.div_wr = 1'b1;
        bus.div_ch = 2'd0; bus.div_val = 8'd0; step("wr_ch0", 7'b0);
        bus.div_ch = 2'd1; bus.div_val = 8'd3; step("wr_ch1", 7'b0);
        bus.div_ch = 2'd2; bus.div_val = 8'd2; step("wr_ch2", 7'b0);
        bus.div_ch = 2'd3; bus.div_val = 8'd9; step("wr_oob", 7'b0);
        bus.div_wr = 1'b0;

        // Full power-up: 20 PWRUP cycles, 4 SETTLE cycles, then RUN.
        bus.req_on = 1'b1;
        step("pu_rise", v(1, 0, 0, 1, 3'b000));
        bus.req_on = 1'b0;
        for (int i = 1; i < PU; i++) step("pwrup", v(1, 0, 0, 1, 3'b000));
        for (int i = 0; i < EN; i++) step("settle", v(1, 1, 0, 1, 3'b000));
        step("run_entry", v(1, 1, 1, 0, 3'b111));

        // RUN: ch1 reprogrammed 5 then 1 mid-period (last wins at the wrap),
        // then an out-of-range write that must not disturb anything.
        for (int k = 1; k <= 12; k++) begin
            bus.div_wr = 1'b0;
            if (k == 2) begin bus.div_wr = 1'b1; bus.div_ch = 2'd1; bus.div_val = 8'd5; end
            if (k == 3) begin bus.div_wr = 1'b1; bus.div_ch = 2'd1; bus.div_val = 8'd1; end
            if (k == 4) begin bus.div_wr = 1'b1; bus.div_ch = 2'd3; bus.div_val = 8'd0; end
            ch1 = (k == 4) || (k >= 6 && (k % 2) == 0);
            ch2 = ((k % 3) == 0);
            step("run_strobe", v(1, 1, 1, 0, {ch2, ch1, 1'b1}));
        end
        bus.div_wr = 1'b0;

        // Shutdown from RUN.
        bus.req_off = 1'b1;
        step("shutdn", v(1, 0, 0, 1, 3'b000));
        bus.req_off = 1'b0;
        step("off_after_shutdn", 7'b0);
        step("off_hold", 7'b0);

        // Simultaneous req_on/req_off in OFF: stays OFF.
        bus.req_on  = 1'b1;
        bus.req_off = 1'b1;
        step("on_off_same", 7'b0);
        bus.req_on  = 1'b0;
        bus.req_off = 1'b0;
        step("stay_off", 7'b0);

        // Abort 5 cycles into PWRUP.
        bus.req_on = 1'b1;
        step("pu_rise2", v(1, 0, 0, 1, 3'b000));
        bus.req_on = 1'b0;
        for (int i = 0; i < 4; i++) step("pwrup2", v(1, 0, 0, 1, 3'b000));
        bus.req_off = 1'b1;
        step("pwrup_abort", 7'b0);
        bus.req_off = 1'b0;
        for (int i = 0; i < 3; i++) step("aborted_idle", 7'b0);

        // Restart with a stray req_on in PWRUP (ignored), then reset mid-SETTLE.
        bus.req_on = 1'b1;
        step("pu_rise3", v(1, 0, 0, 1, 3'b000));
        for (int i = 1; i < PU; i++) begin
            bus.req_on = (i == 5);
            step("pwrup3", v(1, 0, 0, 1, 3'b000));
        end
        bus.req_on = 1'b0;
        for (int i = 0; i < 2; i++) step("settle3", v(1, 1, 0, 1, 3'b000));
        #3 rst = 1'b1;
        #1 check_now("async_rst", 7'b0);
        @(posedge clk);
        #1 check_now("rst_held", 7'b0);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
